// File: rtl/mux_rr_reg.sv
// Registered N-channel, W-bit source multiplexer: manual select register or round-robin scan.
// Latency: 1 cycle from mux_in/ch_req sampled at an open capture slot to mux_out/out_valid.
// Backpressure: while out_valid && !out_ready the output word, ch_sel and rr pointer hold.
//
// Ports:
//   sysclk     sole clock, rising edge
//   sys_rst    synchronous active-high reset (priority over load and capture)
//   mux_in     CHANNELS*WIDTH packed channel data, channel c at [c*WIDTH +: WIDTH]
//   ch_req     per-channel request/valid
//   scan_en    0 = manual select, 1 = round-robin scan
//   sel_in     select value written by sel_load
//   sel_load   load sel_in into the select register and rr pointer
//   out_ready  consumer accepts mux_out this cycle
//   out_valid  mux_out holds a captured word
//   mux_out    registered output word
//   ch_sel     channel index mux_out came from
//   sel_err    one-cycle pulse after a rejected (out-of-range) sel_load
module mux_rr_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      sysclk,
  input  logic                      sys_rst,
  input  logic [CHANNELS*WIDTH-1:0] mux_in,
  input  logic [CHANNELS-1:0]       ch_req,
  input  logic                      scan_en,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      sel_load,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          mux_out,
  output logic [SEL_W-1:0]          ch_sel,
  output logic                      sel_err
);

  // One extra bit so CHANNELS itself is representable for the range check.
  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] selReg;
  logic [SEL_W-1:0] rrPtr;

  logic             slotOpen;
  logic             selOk;

  logic             manReq;
  logic [WIDTH-1:0] manDat;

  logic             hiHit;
  logic             loHit;
  logic [SEL_W-1:0] hiGnt;
  logic [SEL_W-1:0] loGnt;
  logic             scanHit;
  logic [SEL_W-1:0] scanGnt;
  logic [WIDTH-1:0] scanDat;
  logic [SEL_W-1:0] ptrNext;

  assign slotOpen = !out_valid || out_ready;
  assign selOk    = ({1'b0, sel_in} < CH_LIMIT);

  // Manual path: channel addressed by the select register.
  always_comb begin
    manReq = 1'b0;
    manDat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (selReg == SEL_W'(c)) begin
        manReq = ch_req[c];
        manDat = mux_in[c*WIDTH +: WIDTH];
      end
    end
  end

  // Round-robin search in two passes: first the lowest requester at or above
  // rrPtr, otherwise the lowest requester overall (the wrapped part). This
  // avoids any modulo arithmetic, so non-power-of-two counts wrap correctly.
  always_comb begin
    hiHit = 1'b0;
    loHit = 1'b0;
    hiGnt = '0;
    loGnt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!hiHit && ch_req[c] && (SEL_W'(c) >= rrPtr)) begin
        hiHit = 1'b1;
        hiGnt = SEL_W'(c);
      end
      if (!loHit && ch_req[c]) begin
        loHit = 1'b1;
        loGnt = SEL_W'(c);
      end
    end
  end

  assign scanHit = hiHit || loHit;
  assign scanGnt = hiHit ? hiGnt : loGnt;
  assign ptrNext = (scanGnt == LAST_CH) ? '0 : scanGnt + 1'b1;

  always_comb begin
    scanDat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (scanGnt == SEL_W'(c)) begin
        scanDat = mux_in[c*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      selReg    <= '0;
      rrPtr     <= '0;
      out_valid <= 1'b0;
      mux_out   <= '0;
      ch_sel    <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= sel_load && !selOk;

      if (slotOpen) begin
        if (scan_en) begin
          if (scanHit) begin
            out_valid <= 1'b1;
            mux_out   <= scanDat;
            ch_sel    <= scanGnt;
            rrPtr     <= ptrNext;
          end else begin
            out_valid <= 1'b0;
          end
        end else begin
          if (manReq) begin
            out_valid <= 1'b1;
            mux_out   <= manDat;
            ch_sel    <= selReg;
          end else begin
            out_valid <= 1'b0;
          end
        end
      end

      // Placed after the capture so a valid load overrides the post-grant
      // pointer update; the capture itself already used the old values.
      if (sel_load && selOk) begin
        selReg <= sel_in;
        rrPtr  <= sel_in;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
module tb_mux_rr_reg;

  typedef struct packed {
    logic [15:0] dat;
    logic [1:0]  ch;
  } exp_t;

  logic        sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // 4-channel, 16-bit instance
  logic        rst;
  logic [63:0] muxIn;
  logic [3:0]  chReq;
  logic        scanEn;
  logic [1:0]  selIn;
  logic        selLoad;
  logic        outReady;
  logic        outValid;
  logic [15:0] muxOut;
  logic [1:0]  chSel;
  logic        selErr;

  // 3-channel, 8-bit instance
  logic        rst3;
  logic [23:0] muxIn3;
  logic [2:0]  chReq3;
  logic        scanEn3;
  logic [1:0]  selIn3;
  logic        selLoad3;
  logic        outReady3;
  logic        outValid3;
  logic [7:0]  muxOut3;
  logic [1:0]  chSel3;
  logic        selErr3;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t e;

  mux_rr_reg #(.WIDTH(16), .CHANNELS(4)) dut4 (
    .sysclk(sysclk), .sys_rst(rst), .mux_in(muxIn), .ch_req(chReq),
    .scan_en(scanEn), .sel_in(selIn), .sel_load(selLoad), .out_ready(outReady),
    .out_valid(outValid), .mux_out(muxOut), .ch_sel(chSel), .sel_err(selErr)
  );

  mux_rr_reg #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .sysclk(sysclk), .sys_rst(rst3), .mux_in(muxIn3), .ch_req(chReq3),
    .scan_en(scanEn3), .sel_in(selIn3), .sel_load(selLoad3), .out_ready(outReady3),
    .out_valid(outValid3), .mux_out(muxOut3), .ch_sel(chSel3), .sel_err(selErr3)
  );

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic setRamp4();
    for (int c = 0; c < 4; c++) muxIn[c*16 +: 16] = 16'(16'h1000 + c);
  endtask

  task automatic test_reset();
    rst = 1'b1; rst3 = 1'b1;
    muxIn = '0; chReq = '0; scanEn = 1'b0; selIn = '0; selLoad = 1'b0; outReady = 1'b0;
    muxIn3 = '0; chReq3 = '0; scanEn3 = 1'b0; selIn3 = '0; selLoad3 = 1'b0; outReady3 = 1'b0;
    tick();
    tick();
    checks++;
    if (outValid !== 1'b0 || muxOut !== 16'h0 || chSel !== 2'd0 || selErr !== 1'b0) begin
      errors++;
      $display("FAIL reset4: valid=%b out=%h ch=%0d err=%b, required 0/0000/0/0", outValid, muxOut, chSel, selErr);
    end
    checks++;
    if (outValid3 !== 1'b0 || muxOut3 !== 8'h0 || chSel3 !== 2'd0 || selErr3 !== 1'b0) begin
      errors++;
      $display("FAIL reset3: valid=%b out=%h ch=%0d err=%b, required 0/00/0/0", outValid3, muxOut3, chSel3, selErr3);
    end
    rst = 1'b0; rst3 = 1'b0;
  endtask

  task automatic test_manual();
    muxIn = {16'h3333, 16'hA5A5, 16'h1111, 16'h0F0F};
    chReq = 4'b0100; outReady = 1'b1; scanEn = 1'b0;
    selLoad = 1'b1; selIn = 2'd2;
    tick();
    selLoad = 1'b0;
    // capture used the old select 0 whose request is low
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("FAIL manual_load_cycle: out_valid=%b, required 0", outValid);
    end
    sbq.push_back('{dat: 16'hA5A5, ch: 2'd2});
    tick();
    checks++;
    if (!(outValid === 1'b1 && outReady) || sbq.size() == 0) begin
      errors++;
      $display("FAIL manual_word: out_valid=%b queued=%0d, required valid word", outValid, sbq.size());
    end else begin
      e = sbq.pop_front();
      if (muxOut !== e.dat || chSel !== e.ch) begin
        errors++;
        $display("FAIL manual_word: out=%h ch=%0d, required %h ch=%0d", muxOut, chSel, e.dat, e.ch);
      end
    end
    chReq = 4'b0000;
    tick();
    checks++;
    if (outValid !== 1'b0 || muxOut !== 16'hA5A5 || chSel !== 2'd2) begin
      errors++;
      $display("FAIL manual_drop: valid=%b out=%h ch=%0d, required 0/A5A5/2", outValid, muxOut, chSel);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL manual_leftover: %0d words unseen, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_rr_fairness();
    setRamp4();
    scanEn = 1'b1; outReady = 1'b1;
    chReq = 4'b0000; selLoad = 1'b1; selIn = 2'd0;
    tick();
    selLoad = 1'b0;
    chReq = 4'b1111;
    for (int k = 0; k < 8; k++) sbq.push_back('{dat: 16'(16'h1000 + (k % 4)), ch: 2'(k % 4)});
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (!(outValid === 1'b1 && outReady) || sbq.size() == 0) begin
        errors++;
        $display("FAIL rr_all[%0d]: out_valid=%b queued=%0d, required valid word", k, outValid, sbq.size());
        if (sbq.size() != 0) void'(sbq.pop_front());
      end else begin
        e = sbq.pop_front();
        if (muxOut !== e.dat || chSel !== e.ch) begin
          errors++;
          $display("FAIL rr_all[%0d]: out=%h ch=%0d, required %h ch=%0d", k, muxOut, chSel, e.dat, e.ch);
        end
      end
    end
    chReq = 4'b1010;
    for (int k = 0; k < 4; k++) sbq.push_back('{dat: (k % 2 == 0) ? 16'h1001 : 16'h1003, ch: (k % 2 == 0) ? 2'd1 : 2'd3});
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (!(outValid === 1'b1 && outReady) || sbq.size() == 0) begin
        errors++;
        $display("FAIL rr_1010[%0d]: out_valid=%b queued=%0d, required valid word", k, outValid, sbq.size());
        if (sbq.size() != 0) void'(sbq.pop_front());
      end else begin
        e = sbq.pop_front();
        if (muxOut !== e.dat || chSel !== e.ch) begin
          errors++;
          $display("FAIL rr_1010[%0d]: out=%h ch=%0d, required %h ch=%0d", k, muxOut, chSel, e.dat, e.ch);
        end
      end
    end
    chReq = 4'b0000;
    tick();
    checks++;
    if (outValid !== 1'b0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL rr_idle: out_valid=%b leftover=%0d, required 0/0", outValid, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_backpressure();
    chReq = 4'b1111; outReady = 1'b0;
    sbq.push_back('{dat: 16'h1000, ch: 2'd0});
    tick();
    muxIn[15:0] = 16'hDEAD;  // changing the source must not disturb the held word
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (outValid !== 1'b1 || muxOut !== 16'h1000 || chSel !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b out=%h ch=%0d, required 1/1000/0", k, outValid, muxOut, chSel);
      end
      if (k < 3) tick();
    end
    outReady = 1'b1;
    checks++;
    if (!(outValid === 1'b1 && outReady) || sbq.size() == 0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b queued=%0d, required valid word", outValid, sbq.size());
    end else begin
      e = sbq.pop_front();
      if (muxOut !== e.dat || chSel !== e.ch) begin
        errors++;
        $display("FAIL bp_release: out=%h ch=%0d, required %h ch=%0d", muxOut, chSel, e.dat, e.ch);
      end
    end
    sbq.push_back('{dat: 16'h1001, ch: 2'd1});
    tick();
    checks++;
    if (!(outValid === 1'b1 && outReady) || sbq.size() == 0) begin
      errors++;
      $display("FAIL bp_next: out_valid=%b queued=%0d, required valid word", outValid, sbq.size());
    end else begin
      e = sbq.pop_front();
      if (muxOut !== e.dat || chSel !== e.ch) begin
        errors++;
        $display("FAIL bp_next: out=%h ch=%0d, required %h ch=%0d", muxOut, chSel, e.dat, e.ch);
      end
    end
    chReq = 4'b0000;
    setRamp4();
    tick();
    checks++;
    if (outValid !== 1'b0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL bp_idle: out_valid=%b leftover=%0d, required 0/0", outValid, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_simul_load();
    selLoad = 1'b1; selIn = 2'd1; chReq = 4'b0000;
    tick();
    selLoad = 1'b0;
    checks++;
    if (selErr !== 1'b0) begin
      errors++;
      $display("FAIL load_ok_err: sel_err=%b, required 0", selErr);
    end
    chReq = 4'b1111; selLoad = 1'b1; selIn = 2'd3;
    sbq.push_back('{dat: 16'h1001, ch: 2'd1});
    sbq.push_back('{dat: 16'h1003, ch: 2'd3});
    for (int k = 0; k < 2; k++) begin
      tick();
      selLoad = 1'b0;
      checks++;
      if (!(outValid === 1'b1 && outReady) || sbq.size() == 0) begin
        errors++;
        $display("FAIL simul[%0d]: out_valid=%b queued=%0d, required valid word", k, outValid, sbq.size());
        if (sbq.size() != 0) void'(sbq.pop_front());
      end else begin
        e = sbq.pop_front();
        if (muxOut !== e.dat || chSel !== e.ch) begin
          errors++;
          $display("FAIL simul[%0d]: out=%h ch=%0d, required %h ch=%0d", k, muxOut, chSel, e.dat, e.ch);
        end
      end
    end
    chReq = 4'b0000;
    tick();
    checks++;
    if (outValid !== 1'b0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL simul_idle: out_valid=%b leftover=%0d, required 0/0", outValid, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset_stall();
    scanEn = 1'b1; chReq = 4'b0110; outReady = 1'b0;
    tick();  // grants ch1, pointer moves to 2
    checks++;
    if (outValid !== 1'b1 || chSel !== 2'd1) begin
      errors++;
      $display("FAIL rst_stall_pre: valid=%b ch=%0d, required 1/1", outValid, chSel);
    end
    rst = 1'b1; selLoad = 1'b1; selIn = 2'd2;
    tick();
    rst = 1'b0; selLoad = 1'b0;
    checks++;
    if (outValid !== 1'b0 || muxOut !== 16'h0 || chSel !== 2'd0 || selErr !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall: valid=%b out=%h ch=%0d err=%b, required 0/0000/0/0", outValid, muxOut, chSel, selErr);
    end
    outReady = 1'b1;
    sbq.push_back('{dat: 16'h1001, ch: 2'd1});  // lowest requester from pointer 0
    tick();
    checks++;
    if (!(outValid === 1'b1 && outReady) || sbq.size() == 0) begin
      errors++;
      $display("FAIL rst_first_grant: out_valid=%b queued=%0d, required valid word", outValid, sbq.size());
    end else begin
      e = sbq.pop_front();
      if (muxOut !== e.dat || chSel !== e.ch) begin
        errors++;
        $display("FAIL rst_first_grant: out=%h ch=%0d, required %h ch=%0d", muxOut, chSel, e.dat, e.ch);
      end
    end
    // the load during reset must have been ignored: manual select is still 0
    scanEn = 1'b0; chReq = 4'b1111;
    sbq.push_back('{dat: 16'h1000, ch: 2'd0});
    tick();
    checks++;
    if (!(outValid === 1'b1 && outReady) || sbq.size() == 0) begin
      errors++;
      $display("FAIL rst_sel_reg: out_valid=%b queued=%0d, required valid word", outValid, sbq.size());
    end else begin
      e = sbq.pop_front();
      if (muxOut !== e.dat || chSel !== e.ch) begin
        errors++;
        $display("FAIL rst_sel_reg: out=%h ch=%0d, required %h ch=%0d", muxOut, chSel, e.dat, e.ch);
      end
    end
    chReq = 4'b0000;
    tick();
    checks++;
    if (outValid !== 1'b0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL rst_idle: out_valid=%b leftover=%0d, required 0/0", outValid, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_wrap3();
    for (int c = 0; c < 3; c++) muxIn3[c*8 +: 8] = 8'(8'hC0 + c);
    scanEn3 = 1'b1; chReq3 = 3'b111; outReady3 = 1'b1;
    for (int k = 0; k < 6; k++) sbq.push_back('{dat: 16'(16'h00C0 + (k % 3)), ch: 2'(k % 3)});
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (!(outValid3 === 1'b1 && outReady3) || sbq.size() == 0) begin
        errors++;
        $display("FAIL wrap3[%0d]: out_valid=%b queued=%0d, required valid word", k, outValid3, sbq.size());
        if (sbq.size() != 0) void'(sbq.pop_front());
      end else begin
        e = sbq.pop_front();
        if ({8'h00, muxOut3} !== e.dat || chSel3 !== e.ch) begin
          errors++;
          $display("FAIL wrap3[%0d]: out=%h ch=%0d, required %h ch=%0d", k, muxOut3, chSel3, e.dat[7:0], e.ch);
        end
      end
    end
    chReq3 = 3'b000; selLoad3 = 1'b1; selIn3 = 2'd1;
    tick();
    checks++;
    if (selErr3 !== 1'b0 || outValid3 !== 1'b0) begin
      errors++;
      $display("FAIL wrap3_load1: sel_err=%b valid=%b, required 0/0", selErr3, outValid3);
    end
    selIn3 = 2'd3;
    tick();
    selLoad3 = 1'b0;
    checks++;
    if (selErr3 !== 1'b1) begin
      errors++;
      $display("FAIL wrap3_err_pulse: sel_err=%b, required 1", selErr3);
    end
    tick();
    checks++;
    if (selErr3 !== 1'b0) begin
      errors++;
      $display("FAIL wrap3_err_clear: sel_err=%b, required 0", selErr3);
    end
    // select register and pointer must still be 1 after the rejected load
    chReq3 = 3'b111; scanEn3 = 1'b0;
    sbq.push_back('{dat: 16'h00C1, ch: 2'd1});
    sbq.push_back('{dat: 16'h00C1, ch: 2'd1});
    for (int k = 0; k < 2; k++) begin
      tick();
      scanEn3 = 1'b1;
      checks++;
      if (!(outValid3 === 1'b1 && outReady3) || sbq.size() == 0) begin
        errors++;
        $display("FAIL wrap3_sel[%0d]: out_valid=%b queued=%0d, required valid word", k, outValid3, sbq.size());
        if (sbq.size() != 0) void'(sbq.pop_front());
      end else begin
        e = sbq.pop_front();
        if ({8'h00, muxOut3} !== e.dat || chSel3 !== e.ch) begin
          errors++;
          $display("FAIL wrap3_sel[%0d]: out=%h ch=%0d, required %h ch=%0d", k, muxOut3, chSel3, e.dat[7:0], e.ch);
        end
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL wrap3_leftover: %0d words unseen, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_rr_fairness();
    test_backpressure();
    test_simul_load();
    test_reset_stall();
    test_wrap3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
